// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: forwarding select encodings,
// the "operand unused" Tuse code, default MD unit latencies and a register-match helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10,
        FWD_E  = 2'b11
    } fwd_sel_e;

    localparam logic [1:0]  TUSE_NONE       = 2'd3;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // A writing stage matches a source register; $0 never matches.
    function automatic logic reg_hit(input logic we, input logic [4:0] a3, input logic [4:0] src);
        return we && (a3 != 5'd0) && (a3 == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// Busy counter modelling the multi-cycle mult/div unit; md_busy is high while
// the count is non-zero. Starts arriving while the count is non-zero are ignored.
module md_busy_cnt
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_md_busy
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_next;

    always_comb begin
        w_next = r_count;
        if (r_count != '0) begin
            w_next = r_count - CNT_W'(1);
        end else if (i_start) begin
            w_next = i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else begin
            r_count <= w_next;
        end
    end

    assign o_md_busy = (r_count != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble generation, operand forwarding selects
// and MD-unit sequencing. Define HAZARD_PERF_EN to build the saturating stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_rs,
    input  logic [4:0]  e_rt,
    input  logic [4:0]  e_a3,
    input  logic [4:0]  m_a3,
    input  logic [4:0]  w_a3,
    input  logic        e_regwe,
    input  logic        m_regwe,
    input  logic        w_regwe,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    input  logic [4:0]  m_rt,
    output logic        pc_en,
    output logic        fd_en,
    output logic        de_clr,
    output logic [1:0]  fwd_d_rs,
    output logic [1:0]  fwd_d_rt,
    output logic [1:0]  fwd_e_rs,
    output logic [1:0]  fwd_e_rt,
    output logic        fwd_m_rt,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    logic w_md_busy;
    logic w_stall_rs;
    logic w_stall_rt;
    logic w_stall_md;
    logic w_stall;

    md_busy_cnt #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_cnt (
        .clk       (clk),
        .reset     (reset),
        .i_start   (e_md_start),
        .i_is_div  (e_md_div),
        .o_md_busy (w_md_busy)
    );

    assign md_busy = w_md_busy;

    // A producer stalls D only when its result arrives later than D needs it.
    assign w_stall_rs = (d_tuse_rs != TUSE_NONE) &&
                        ((reg_hit(e_regwe, e_a3, d_rs) && (e_tnew > d_tuse_rs)) ||
                         (reg_hit(m_regwe, m_a3, d_rs) && (m_tnew > d_tuse_rs)));
    assign w_stall_rt = (d_tuse_rt != TUSE_NONE) &&
                        ((reg_hit(e_regwe, e_a3, d_rt) && (e_tnew > d_tuse_rt)) ||
                         (reg_hit(m_regwe, m_a3, d_rt) && (m_tnew > d_tuse_rt)));
    assign w_stall_md = d_is_md && (w_md_busy || e_md_start);
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

    assign pc_en  = !w_stall;
    assign fd_en  = !w_stall;
    assign de_clr = w_stall;

    always_comb begin
        fwd_d_rs = FWD_RF;
        if (reg_hit(e_regwe, e_a3, d_rs) && (e_tnew == 2'd0)) begin
            fwd_d_rs = FWD_E;
        end else if (reg_hit(m_regwe, m_a3, d_rs) && (m_tnew == 2'd0)) begin
            fwd_d_rs = FWD_M;
        end else if (reg_hit(w_regwe, w_a3, d_rs)) begin
            fwd_d_rs = FWD_W;
        end

        fwd_d_rt = FWD_RF;
        if (reg_hit(e_regwe, e_a3, d_rt) && (e_tnew == 2'd0)) begin
            fwd_d_rt = FWD_E;
        end else if (reg_hit(m_regwe, m_a3, d_rt) && (m_tnew == 2'd0)) begin
            fwd_d_rt = FWD_M;
        end else if (reg_hit(w_regwe, w_a3, d_rt)) begin
            fwd_d_rt = FWD_W;
        end

        fwd_e_rs = FWD_RF;
        if (reg_hit(m_regwe, m_a3, e_rs) && (m_tnew == 2'd0)) begin
            fwd_e_rs = FWD_M;
        end else if (reg_hit(w_regwe, w_a3, e_rs)) begin
            fwd_e_rs = FWD_W;
        end

        fwd_e_rt = FWD_RF;
        if (reg_hit(m_regwe, m_a3, e_rt) && (m_tnew == 2'd0)) begin
            fwd_e_rt = FWD_M;
        end else if (reg_hit(w_regwe, w_a3, e_rt)) begin
            fwd_e_rt = FWD_W;
        end
    end

    assign fwd_m_rt = reg_hit(w_regwe, w_a3, m_rt);

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the hazard rules.
module tb_hazard_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  d_rs, d_rt, e_rs, e_rt, e_a3, m_a3, w_a3, m_rt;
    logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
    logic        d_is_md, e_regwe, m_regwe, w_regwe, e_md_start, e_md_div;
    logic        pc_en, fd_en, de_clr, fwd_m_rt, md_busy;
    logic [1:0]  fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
    logic [31:0] stall_cnt;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          busy_end = -1;
    logic [31:0] exp_sc = '0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
        .d_is_md(d_is_md), .e_rs(e_rs), .e_rt(e_rt),
        .e_a3(e_a3), .m_a3(m_a3), .w_a3(w_a3),
        .e_regwe(e_regwe), .m_regwe(m_regwe), .w_regwe(w_regwe),
        .e_tnew(e_tnew), .m_tnew(m_tnew),
        .e_md_start(e_md_start), .e_md_div(e_md_div), .m_rt(m_rt),
        .pc_en(pc_en), .fd_en(fd_en), .de_clr(de_clr),
        .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
        .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt),
        .fwd_m_rt(fwd_m_rt), .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit hit(input logic we, input logic [4:0] a3, input logic [4:0] src);
        return we && a3 != 0 && a3 == src;
    endfunction

    function automatic bit model_busy();
        return reset && (cyc <= busy_end);
    endfunction

    function automatic bit data_stall(input logic [4:0] src, input logic [1:0] tuse);
        if (tuse == 3) return 0;
        return (hit(e_regwe, e_a3, src) && int'(e_tnew) > int'(tuse)) ||
               (hit(m_regwe, m_a3, src) && int'(m_tnew) > int'(tuse));
    endfunction

    function automatic bit model_stall();
        return data_stall(d_rs, d_tuse_rs) || data_stall(d_rt, d_tuse_rt) ||
               (d_is_md && (model_busy() || e_md_start));
    endfunction

    // Walk producer stages youngest-first; first ready match wins.
    function automatic logic [1:0] model_fwd(input logic [4:0] src, input bit from_d);
        logic [4:0] a3s [3];
        logic       wes [3];
        int         rdy [3];
        logic [1:0] code [3];
        a3s  = '{e_a3, m_a3, w_a3};
        wes  = '{e_regwe, m_regwe, w_regwe};
        rdy  = '{int'(e_tnew), int'(m_tnew), 0};
        code = '{2'b11, 2'b10, 2'b01};
        for (int s = (from_d ? 0 : 1); s < 3; s++)
            if (hit(wes[s], a3s[s], src) && rdy[s] == 0) return code[s];
        return 2'b00;
    endfunction

    task automatic check_all();
        bit st;
        st = model_stall();
        chk("pc_en",    {31'd0, pc_en},    {31'd0, !st});
        chk("fd_en",    {31'd0, fd_en},    {31'd0, !st});
        chk("de_clr",   {31'd0, de_clr},   {31'd0, st});
        chk("fwd_d_rs", {30'd0, fwd_d_rs}, {30'd0, model_fwd(d_rs, 1)});
        chk("fwd_d_rt", {30'd0, fwd_d_rt}, {30'd0, model_fwd(d_rt, 1)});
        chk("fwd_e_rs", {30'd0, fwd_e_rs}, {30'd0, model_fwd(e_rs, 0)});
        chk("fwd_e_rt", {30'd0, fwd_e_rt}, {30'd0, model_fwd(e_rt, 0)});
        chk("fwd_m_rt", {31'd0, fwd_m_rt}, {31'd0, hit(w_regwe, w_a3, m_rt)});
        chk("md_busy",  {31'd0, md_busy},  {31'd0, model_busy()});
`ifdef HAZARD_PERF_EN
        chk("stall_cnt", stall_cnt, exp_sc);
`else
        chk("stall_cnt", stall_cnt, 32'd0);
`endif
    endtask

    task automatic model_edge();
        if (reset) begin
            if (model_stall() && exp_sc != 32'hFFFF_FFFF) exp_sc++;
            if (e_md_start) begin
                if (!model_busy()) busy_end = cyc + (e_md_div ? DIV_N : MULT_N);
                else $display("note: md start ignored while unit busy (cycle %0d)", cyc);
            end
        end
        cyc++;
    endtask

    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic clear_inputs();
        {d_rs, d_rt, e_rs, e_rt, e_a3, m_a3, w_a3, m_rt} = '0;
        {d_tuse_rs, d_tuse_rt, e_tnew, m_tnew} = '0;
        {d_is_md, e_regwe, m_regwe, w_regwe, e_md_start, e_md_div} = '0;
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        step();                                  // reset state
        reset = 1'b1;
        step();

        // load-use: E producer, then M producer, then W forward
        e_a3 = 1; e_regwe = 1; e_tnew = 2; d_rs = 1; d_tuse_rs = 0;
        step();
        e_regwe = 0; e_a3 = 0; m_a3 = 1; m_regwe = 1; m_tnew = 1;
        step();
        m_regwe = 0; m_a3 = 0; w_a3 = 1; w_regwe = 1;
        step();
        d_tuse_rs = 1; e_a3 = 1; e_regwe = 1; e_tnew = 2; w_regwe = 0;
        step();
        clear_inputs();

        // M forward with no stall
        m_a3 = 2; m_regwe = 1; d_rs = 2;
        step();
        clear_inputs();

        // priority E > M > W for D, M > W for E, store-data forward
        e_a3 = 3; m_a3 = 3; w_a3 = 3; e_regwe = 1; m_regwe = 1; w_regwe = 1;
        d_rt = 3; e_rt = 3; e_rs = 3; m_rt = 3;
        step();
        m_tnew = 1;
        step();
        clear_inputs();

        // $0 never stalls or forwards
        e_regwe = 1; e_tnew = 2; w_regwe = 1;
        step();
        clear_inputs();

        // mult then div with an MD consumer waiting in D
        d_is_md = 1; e_md_start = 1; e_md_div = 0;
        step();
        e_md_start = 0;
        repeat (MULT_N + 1) step();
        e_md_start = 1; e_md_div = 1;
        step();
        e_md_start = 0;
        repeat (DIV_N + 1) step();

        // start coinciding with the final decrement is dropped
        e_md_start = 1; e_md_div = 0;
        step();
        e_md_start = 0;
        repeat (MULT_N - 1) step();
        e_md_start = 1;
        step();
        e_md_start = 0;
        step();

        // async reset in the middle of a div
        e_md_start = 1; e_md_div = 1;
        step();
        e_md_start = 0;
        repeat (3) step();                       // count now 7
        #1;
        reset = 1'b0;
        busy_end = -1;
        exp_sc = '0;
        #1;
        chk("rst_md_busy",   {31'd0, md_busy}, 32'd0);
        chk("rst_stall_cnt", stall_cnt,        32'd0);
        d_is_md = 0;
        step();
        reset = 1'b1;
        d_is_md = 1;
        step();
        clear_inputs();

        // random traffic over a small register window to provoke matches
        for (int n = 0; n < 400; n++) begin
            d_rs = 5'($urandom_range(0, 3));      d_rt = 5'($urandom_range(0, 3));
            e_rs = 5'($urandom_range(0, 3));      e_rt = 5'($urandom_range(0, 3));
            e_a3 = 5'($urandom_range(0, 3));      m_a3 = 5'($urandom_range(0, 3));
            w_a3 = 5'($urandom_range(0, 3));      m_rt = 5'($urandom_range(0, 3));
            d_tuse_rs = 2'($urandom_range(0, 3)); d_tuse_rt = 2'($urandom_range(0, 3));
            e_tnew = 2'($urandom_range(0, 2));    m_tnew = 2'($urandom_range(0, 1));
            e_regwe = 1'($urandom); m_regwe = 1'($urandom); w_regwe = 1'($urandom);
            d_is_md = ($urandom_range(0, 3) == 0);
            e_md_start = ($urandom_range(0, 7) == 0);
            e_md_div = 1'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit expired");
    end

endmodule
